// File: rtl/booth_multiplier_core_pkg.sv
// Shared definitions for the Booth multiplier datapath: state encoding, Booth-op
// decode and the Count phase meaning shared with the upstream controller.
package booth_multiplier_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  // Count phase: 0 is register initialisation, 1..WIDTH are Booth steps.
  localparam int COUNT_INIT = 0;
  localparam int COUNT_FIRST_STEP = 1;

  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_multiplier_core_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A followed by an
// arithmetic shift right of {A,Q,Q_1}. Purely combinational.
module booth_step
  import booth_multiplier_core_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  // A carries one guard bit so that negating the most-negative M cannot overflow.
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  booth_op_t      op;

  assign m_ext = {m[WIDTH-1], m};
  assign op    = booth_decode(q[0], q_1);

  always_comb begin
    sum = a;
    case (op)
      ADD:     sum = a + m_ext;
      SUB:     sum = a - m_ext;
      default: sum = a;
    endcase
  end

  assign a_next   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_multiplier_core.sv
// Self-sequencing radix-2 Booth signed multiplier with Start/Busy/Done handshake;
// Product is held until the next completed operation, Clear or reset.
module booth_multiplier_core
  import booth_multiplier_core_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      count,
  output logic [2*WIDTH-1:0] product
);

  state_t               state_reg, state_next;
  logic [WIDTH:0]       a_reg;
  logic [WIDTH-1:0]     q_reg;
  logic                 q_1_reg;
  logic [WIDTH-1:0]     m_reg;
  logic [CW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic [WIDTH:0]       a_step;
  logic [WIDTH-1:0]     q_step;
  logic                 q_1_step;
  logic                 last_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_reg),
    .q        (q_reg),
    .q_1      (q_1_reg),
    .m        (m_reg),
    .a_next   (a_step),
    .q_next   (q_step),
    .q_1_next (q_1_step)
  );

  assign last_step = (count_reg == CW'(WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = LOAD;
        LOAD:    state_next = STEP;
        STEP:    if (last_step) state_next = DONE;
        DONE:    state_next = start ? LOAD : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg       <= '0;
      q_reg       <= '0;
      q_1_reg     <= 1'b0;
      m_reg       <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else if (clear) begin
      a_reg       <= '0;
      q_reg       <= '0;
      q_1_reg     <= 1'b0;
      count_reg   <= CW'(COUNT_INIT);
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // Operands are only latched when a new request is accepted.
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
          end
          count_reg <= CW'(COUNT_INIT);
        end
        LOAD: begin
          a_reg     <= '0;
          q_1_reg   <= 1'b0;
          count_reg <= CW'(COUNT_FIRST_STEP);
        end
        STEP: begin
          a_reg   <= a_step;
          q_reg   <= q_step;
          q_1_reg <= q_1_step;
          if (last_step) begin
            product_reg <= {a_step[WIDTH-1:0], q_step};
            count_reg   <= CW'(COUNT_INIT);
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        default: count_reg <= CW'(COUNT_INIT);
      endcase
    end
  end

  assign busy    = (state_reg == LOAD) || (state_reg == STEP);
  assign done    = (state_reg == DONE);
  assign count   = count_reg;
  assign product = product_reg;

endmodule
